gray_window_buffer: RTL
=======================

GRAY_WINDOW_BUFFER -- requirements
Module: gray_window_buffer

Interface
REQ-001 The block SHALL have parameter PIXEL_WIDTH_OUT, default 8, which is the gray pixel width in bits.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 16, which is the pixels per line (minimum 3).
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 16, which is the lines per frame (minimum 3).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have port px_rdy_i, input, 1 bit: gray pixel valid strobe from the gray-scale stage.
REQ-007 The block SHALL have port in_px_gray_i, input, PIXEL_WIDTH_OUT bits: gray pixel, raster order.
REQ-008 The block SHALL have port window_o, output, 9*PIXEL_WIDTH_OUT bits: 3x3 neighbourhood; element k occupies bits [8k+7:8k].
REQ-009 The block SHALL have port px_rdy_o, output, 1 bit: window_o is a valid full window this cycle.
REQ-010 The block SHALL have port frame_done_o, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 A pixel SHALL be accepted on every rising edge where px_rdy_i=1; with px_rdy_i=0, counters, line buffers and window SHALL hold.
REQ-012 The column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) SHALL describe the position of the accepted pixel.
- col increments per accept and wraps to 0 after IMG_WIDTH-1, at which point row increments.
- row wraps to 0 after IMG_HEIGHT-1.
REQ-013 The block SHALL hold two line buffers of IMG_WIDTH pixels, delaying the stream by exactly one line and two lines, updated only on accept.
REQ-014 On accepting pixel P(r,c), the window SHALL shift left by one column and load the new right column as follows.
- Element 2 = P(r-2,c).
- Element 5 = P(r-1,c).
- Element 8 = P(r,c).
- Elements 0/1, 3/4 and 6/7 receive the former elements 1/2, 4/5 and 7/8.
- Resulting layout: element 0 = top-left, element 8 = bottom-right, row-major.
REQ-015 px_rdy_o SHALL be registered: it SHALL equal 1 in the cycle after accepting P(r,c) when r>=2 and c>=2, and 0 otherwise, including every cycle with px_rdy_i=0 (latency 1, same as the gray stage).
REQ-016 window_o SHALL change only on accepted pixels; its value while px_rdy_o=0 is don't-care but SHALL be stable.
REQ-017 The FSM SHALL have states IDLE, FILL and STREAM.
- IDLE -> FILL on the first accept.
- FILL -> STREAM on accepting P(2,0).
- STREAM -> FILL on accepting P(IMG_HEIGHT-1,IMG_WIDTH-1).
- FILL and STREAM SHALL never return to IDLE except via reset.
REQ-018 frame_done_o SHALL be 1 for exactly one cycle after accepting P(IMG_HEIGHT-1,IMG_WIDTH-1); the next accept SHALL be treated as P(0,0) of a new frame.
REQ-019 Line buffer contents SHALL NOT be cleared at frame wrap; stale data SHALL be masked solely by REQ-015.
REQ-020 Window columns straddling a line boundary (c<2) SHALL NOT produce px_rdy_o=1.
REQ-021 No arithmetic SHALL be performed on pixel data; values SHALL pass through bit-exact.

Reset
REQ-022 While reset_i=1, the block SHALL asynchronously set the following.
- px_rdy_o=0 and frame_done_o=0.
- window_o=0.
- col=0, row=0, FSM=IDLE.
- Line buffers to 0.
REQ-023 On reset asserted mid-frame, the block SHALL discard partial frame state, and the first accept after release SHALL be P(0,0).
REQ-024 Deassertion of reset_i SHALL take effect at the next rising edge with no extra wait cycles.

Verification
REQ-025 The bench SHALL cover these directed scenarios with IMG_WIDTH=4, IMG_HEIGHT=4 and pixel value = 16*r+c.
- Continuous frame of 16 accepts -> px_rdy_o high exactly 4 times. The first window is {00,01,02,10,11,12,20,21,22}; the last is {11,12,13,21,22,23,31,32,33}.
- Same frame with px_rdy_i deasserted 3 cycles between every pixel -> identical 4 windows in the same order; px_rdy_o never high during gaps, window_o stable during gaps.
- Two back-to-back frames -> frame_done_o pulses exactly once after accept 16 and once after accept 32. The second frame yields 4 windows with no window mixing frame-1 rows, and px_rdy_o is low for all rows 0-1 of frame 2.
- Reset asserted after accepting P(2,2) -> all outputs read 0 during reset. After release, the next 16 accepts reproduce the first scenario exactly.
- Boundary accepts P(2,0) and P(2,1) -> px_rdy_o=0; P(2,2) -> px_rdy_o=1; P(3,0) -> px_rdy_o=0.
- Reset asserted and released in the same cycle as px_rdy_i=1 -> that pixel is not accepted, and the state reads IDLE afterwards.

Source files
------------

// File: rtl/gray_window_buffer.sv
// rtl/gray_window_buffer.sv - 3x3 gray pixel window generator with two line buffers
module gray_window_buffer #(
    parameter int PIXEL_WIDTH_OUT = 8,
    parameter int IMG_WIDTH       = 16,
    parameter int IMG_HEIGHT      = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         px_rdy_i,
    input  logic [PIXEL_WIDTH_OUT-1:0]   in_px_gray_i,
    output logic [9*PIXEL_WIDTH_OUT-1:0] window_o,
    output logic                         px_rdy_o,
    output logic                         frame_done_o
);

    localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    // Line 1 holds the previous line, line 2 the line before that.
    logic [PIXEL_WIDTH_OUT-1:0] line1_q [IMG_WIDTH];
    logic [PIXEL_WIDTH_OUT-1:0] line2_q [IMG_WIDTH];

    // Window elements, row-major: 0 top-left, 8 bottom-right.
    logic [PIXEL_WIDTH_OUT-1:0] win_q [9];

    logic                       accept;
    logic                       col_last;
    logic                       row_last;
    logic                       frame_last;
    logic                       window_full;
    logic [PIXEL_WIDTH_OUT-1:0] tap1;
    logic [PIXEL_WIDTH_OUT-1:0] tap2;

    // Position decode and line buffer read taps for the pixel being accepted.
    always_comb begin
        accept      = px_rdy_i;
        col_last    = (col_q == COL_LAST);
        row_last    = (row_q == ROW_LAST);
        frame_last  = col_last && row_last;
        window_full = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
        tap1        = line1_q[col_q];
        tap2        = line2_q[col_q];
    end

    // Column/row raster counters; the row advances when the column wraps.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Line buffers: the column slot is read before being overwritten, giving
    // exactly one- and two-line delays. Contents survive frame wrap.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                line1_q[i] <= '0;
                line2_q[i] <= '0;
            end
        end else if (accept) begin
            line1_q[col_q] <= in_px_gray_i;
            line2_q[col_q] <= tap1;
        end
    end

    // Window shifts left one column per accept; new right column from the
    // two-line tap, the one-line tap and the incoming pixel.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]     <= win_q[3*r + 1];
                win_q[3*r + 1] <= win_q[3*r + 2];
            end
            win_q[2] <= tap2;
            win_q[5] <= tap1;
            win_q[8] <= in_px_gray_i;
        end
    end

    // Registered strobes: a full window exists only once two earlier lines
    // and two earlier columns of the current line have been seen.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            px_rdy_o     <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            px_rdy_o     <= accept && window_full;
            frame_done_o <= accept && frame_last;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: FILL while the line buffers are priming, STREAM once
    // row 2 starts, back to FILL at the end of each frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (accept && (row_q == ROW_TWO) && (col_q == '0)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && frame_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pack the window elements onto the flat output bus.
    genvar gk;
    generate
        for (gk = 0; gk < 9; gk++) begin : g_pack
            assign window_o[gk*PIXEL_WIDTH_OUT +: PIXEL_WIDTH_OUT] = win_q[gk];
        end
    endgenerate

endmodule
